// File: rtl/rx_frame_buffer_if.sv
// Bus between the UART-side producer / frame consumer and rx_frame_buffer.
//   master: drives RxData, isNewData, frameRelease, rdAddr; observes status and read data.
//   slave : the frame buffer itself.
interface rx_frame_buffer_if #(
  parameter int unsigned addrWidth = 12
) ();
  logic [7:0]           RxData;
  logic                 isNewData;
  logic                 frameRelease;
  logic [addrWidth-1:0] rdAddr;
  logic [7:0]           rdData;
  logic                 frameReady;
  logic [15:0]          wrRow;
  logic [15:0]          wrCol;
  logic [15:0]          frameCount;
  logic                 overflow;

  modport master (
    output RxData, isNewData, frameRelease, rdAddr,
    input  rdData, frameReady, wrRow, wrCol, frameCount, overflow
  );

  modport slave (
    input  RxData, isNewData, frameRelease, rdAddr,
    output rdData, frameReady, wrRow, wrCol, frameCount, overflow
  );
endinterface

// File: rtl/rx_frame_buffer.sv
// Captures one image frame of bytes from a UART receiver into internal memory.
// Ports:
//   clk   - single rising-edge clock
//   reset - synchronous active-high reset (memory contents are kept)
//   bus   - rx_frame_buffer_if.slave:
//             RxData/isNewData : incoming byte, isNewData toggles once per byte
//             frameRelease     : consumer pulse, frame read, buffer may refill
//             rdAddr/rdData    : read port, 1-cycle registered latency
//             frameReady, wrRow, wrCol, frameCount, overflow : status
module rx_frame_buffer #(
  parameter int unsigned imageWidth  = 64,
  parameter int unsigned imageHeight = 64,
  parameter int unsigned addrWidth   = 12
) (
  input logic            clk,
  input logic            reset,
  rx_frame_buffer_if.slave bus
);

  localparam int unsigned Depth = imageWidth * imageHeight;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [addrWidth-1:0] LastAddr = addrWidth'(Depth - 1);
  localparam logic [addrWidth:0]   DepthExt = (addrWidth + 1)'(Depth);
  localparam logic [15:0]          LastCol  = 16'(imageWidth - 1);

  localparam logic [0:0] StFill = 1'b0;
  localparam logic [0:0] StFull = 1'b1;

  logic [7:0] mem [Depth];

  logic [0:0]           state_q, state_d;
  logic [addrWidth-1:0] wrAddr_q, wrAddr_d;
  logic [15:0]          wrRow_q, wrRow_d;
  logic [15:0]          wrCol_q, wrCol_d;
  logic [15:0]          frameCount_q, frameCount_d;
  logic                 frameReady_q, frameReady_d;
  logic                 overflow_q, overflow_d;
  logic                 prevNew_q;
  logic [7:0]           rdData_q;

  logic newByte;
  logic fill_en;
  logic we;

  // Each edge of isNewData marks exactly one received byte.
  assign newByte = bus.isNewData ^ prevNew_q;

  always_comb begin
    state_d      = state_q;
    wrAddr_d     = wrAddr_q;
    wrRow_d      = wrRow_q;
    wrCol_d      = wrCol_q;
    frameCount_d = frameCount_q;
    frameReady_d = frameReady_q;
    overflow_d   = overflow_q;
    we           = 1'b0;

    // A release while full reopens the buffer in the same cycle, so a byte
    // arriving alongside it lands at address 0 (write pointers are already 0).
    fill_en = (state_q == StFill) || bus.frameRelease;

    if ((state_q == StFull) && bus.frameRelease) begin
      state_d      = StFill;
      frameReady_d = 1'b0;
    end

    if (newByte) begin
      if (fill_en) begin
        we = 1'b1;
        if (wrAddr_q == LastAddr) begin
          state_d      = StFull;
          frameReady_d = 1'b1;
          wrAddr_d     = '0;
          wrRow_d      = '0;
          wrCol_d      = '0;
          frameCount_d = frameCount_q + 16'd1;
        end else begin
          wrAddr_d = wrAddr_q + 1'b1;
          if (wrCol_q == LastCol) begin
            wrCol_d = '0;
            wrRow_d = wrRow_q + 16'd1;
          end else begin
            wrCol_d = wrCol_q + 16'd1;
          end
        end
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFill;
      wrAddr_q     <= '0;
      wrRow_q      <= '0;
      wrCol_q      <= '0;
      frameCount_q <= '0;
      frameReady_q <= 1'b0;
      overflow_q   <= 1'b0;
      prevNew_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrAddr_q     <= wrAddr_d;
      wrRow_q      <= wrRow_d;
      wrCol_q      <= wrCol_d;
      frameCount_q <= frameCount_d;
      frameReady_q <= frameReady_d;
      overflow_q   <= overflow_d;
      prevNew_q    <= bus.isNewData;
    end
  end

  // Memory is never cleared; a byte coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[wrAddr_q[IdxW-1:0]] <= bus.RxData;
    end
  end

  // Registered read gives old data on a same-address write; out-of-range
  // addresses simply hold the previous value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdData_q <= '0;
    end else if ({1'b0, bus.rdAddr} < DepthExt) begin
      rdData_q <= mem[bus.rdAddr[IdxW-1:0]];
    end
  end

  assign bus.rdData     = rdData_q;
  assign bus.frameReady = frameReady_q;
  assign bus.wrRow      = wrRow_q;
  assign bus.wrCol      = wrCol_q;
  assign bus.frameCount = frameCount_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_rx_frame_buffer.sv
module tb_rx_frame_buffer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk;
  logic reset;

  rx_frame_buffer_if #(.addrWidth(12)) bus ();

  rx_frame_buffer #(
    .imageWidth (W),
    .imageHeight(H),
    .addrWidth  (12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame contents plus how many bytes of the current frame are in.
  logic [7:0] m_mem [N];
  bit         m_val [N];
  int         m_pos;
  bit         m_full;
  int         m_cnt;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("frameReady", {31'd0, bus.frameReady}, {31'd0, m_full});
    chk("wrRow", {16'd0, bus.wrRow}, 32'(m_pos / W));
    chk("wrCol", {16'd0, bus.wrCol}, 32'(m_pos % W));
    chk("frameCount", {16'd0, bus.frameCount}, 32'(m_cnt));
    chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
  endtask

  task automatic model(input bit en, input logic [7:0] b, input bit rel);
    if (m_full && rel) m_full = 1'b0;
    if (en) begin
      if (!m_full) begin
        m_mem[m_pos] = b;
        m_val[m_pos] = 1'b1;
        m_pos++;
        if (m_pos == N) begin
          m_pos  = 0;
          m_full = 1'b1;
          m_cnt  = (m_cnt + 1) % 65536;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // One clock of stimulus: optional byte, optional release, optional read (ra < 0: none).
  task automatic step(input bit en, input logic [7:0] b, input bit rel, input int ra);
    logic [7:0] exp_rd;
    bit         rd_ok;
    int         idx;
    idx = (ra < 0) ? 0 : ra;
    @(negedge clk);
    bus.RxData       = b;
    bus.frameRelease = rel;
    if (en) bus.isNewData = ~bus.isNewData;
    if (ra >= 0) bus.rdAddr = 12'(ra);
    rd_ok  = (ra >= 0) && m_val[idx];
    exp_rd = m_mem[idx];
    @(posedge clk);
    #1;
    bus.frameRelease = 1'b0;
    model(en, b, rel);
    if (rd_ok) chk("rdData", {24'd0, bus.rdData}, {24'd0, exp_rd});
    check_state();
  endtask

  // isNewData is returned low during reset, like an upstream receiver reset.
  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b1;
    bus.isNewData    = 1'b0;
    bus.frameRelease = 1'b0;
    bus.RxData       = 8'hEE;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_pos  = 0;
    m_full = 1'b0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    chk("rdData_reset", {24'd0, bus.rdData}, 32'd0);
    check_state();
  endtask

  initial begin
    reset            = 1'b1;
    bus.RxData       = '0;
    bus.isNewData    = 1'b0;
    bus.frameRelease = 1'b0;
    bus.rdAddr       = '0;
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    m_pos = 0; m_full = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Five bytes -> row 1, col 1, not ready.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, -1);
    chk("req035_row", {16'd0, bus.wrRow}, 32'd1);
    chk("req035_col", {16'd0, bus.wrCol}, 32'd1);
    do_reset();

    // Constant isNewData: nothing is written.
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(posedge clk);
      #1;
      chk("idle_col", {16'd0, bus.wrCol}, 32'd0);
      chk("idle_ready", {31'd0, bus.frameReady}, 32'd0);
    end

    // Full frame 0x00..0x0F.
    for (int i = 0; i < N; i++) step(1'b1, 8'(i), 1'b0, -1);
    chk("req034_ready", {31'd0, bus.frameReady}, 32'd1);
    chk("req034_count", {16'd0, bus.frameCount}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 5);
    chk("req034_rd5", {24'd0, bus.rdData}, 32'h05);

    // Overflow while full: memory untouched.
    step(1'b1, 8'hAA, 1'b0, -1);
    chk("req036_ovf", {31'd0, bus.overflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 0);
    chk("req036_rd0", {24'd0, bus.rdData}, 32'h00);

    // Release and byte together: byte goes to address 0.
    step(1'b1, 8'h55, 1'b1, -1);
    chk("req037_col", {16'd0, bus.wrCol}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 0);
    chk("req037_rd0", {24'd0, bus.rdData}, 32'h55);

    // Release while filling is ignored.
    step(1'b0, 8'h00, 1'b1, -1);

    // Partial frame discarded by reset.
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, -1);
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, 8'(8'h20 + i), 1'b0, -1);
    step(1'b0, 8'h00, 1'b0, 0);
    chk("req038_rd0", {24'd0, bus.rdData}, 32'h20);
    chk("req038_count", {16'd0, bus.frameCount}, 32'd1);

    // Random traffic, including reads that collide with writes.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, N - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
